// File: rtl/vga_sync_gen_pkg.sv
// Shared raster geometry for the sync generator, frame counter and overlay blocks.
// Defaults describe 640x480 VGA; the decode helper gives every consumer identical region boundaries.
package vga_sync_gen_pkg;

    localparam int unsigned DEF_CNT_W    = 11;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;

    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    typedef struct packed {
        logic in_sync;
        logic in_active;
    } axis_decode_t;

    function automatic int unsigned axis_total(
        input int unsigned active,
        input int unsigned fp,
        input int unsigned sync,
        input int unsigned bp
    );
        return active + fp + sync + bp;
    endfunction

    localparam int unsigned DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int unsigned DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

    // Sync sits after the front porch; the back porch only pads the total.
    function automatic axis_decode_t axis_decode(
        input int unsigned count,
        input int unsigned active,
        input int unsigned fp,
        input int unsigned sync
    );
        axis_decode_t d;
        d.in_active = (count < active);
        d.in_sync   = (count >= (active + fp)) && (count < (active + fp + sync));
        return d;
    endfunction

endpackage

// File: rtl/vga_sync_gen_sync_axis_counter.sv
// One raster axis: a wrapping position counter plus its registered sync decode.
// The decode is taken from the next-state count so the sync register lines up with the count register.
module sync_axis_counter
    import vga_sync_gen_pkg::*;
#(
    parameter int unsigned ACTIVE      = DEF_H_ACTIVE,
    parameter int unsigned FP          = DEF_H_FP,
    parameter int unsigned SYNC        = DEF_H_SYNC,
    parameter int unsigned BP          = DEF_H_BP,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter bit          SYNC_ACTIVE = 1'b0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             advance_i,
    output logic [CNT_W-1:0] count_o,
    output logic             sync_o,
    output logic             at_last_o,
    output logic             active_next_o
);

    localparam int unsigned      TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TOTAL - 32'd1);
    localparam logic [CNT_W-1:0] ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             sync_q;
    logic             sync_d;
    axis_decode_t     dec_s;

    // Next count: hold, step, or wrap from TOTAL-1 back to zero.
    always_comb begin
        count_d = count_q;
        if (advance_i) begin
            if (count_q == LAST) begin
                count_d = ZERO;
            end else begin
                count_d = count_q + ONE;
            end
        end else begin
            count_d = count_q;
        end
    end

    // Region decode of the position this axis is about to show.
    always_comb begin
        dec_s  = axis_decode(32'(count_d), ACTIVE, FP, SYNC);
        sync_d = ~SYNC_ACTIVE;
        if (dec_s.in_sync) begin
            sync_d = SYNC_ACTIVE;
        end else begin
            sync_d = ~SYNC_ACTIVE;
        end
    end

    // Position and sync registers; reset parks on the last position so the first advance lands on zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= LAST;
            sync_q  <= ~SYNC_ACTIVE;
        end else begin
            count_q <= count_d;
            sync_q  <= sync_d;
        end
    end

    assign count_o       = count_q;
    assign sync_o        = sync_q;
    assign at_last_o     = (count_q == LAST);
    assign active_next_o = dec_s.in_active;

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing source: coordinates, syncs, blank and line/frame start strobes, all registered together.
// The vertical axis advances only on the enabled edge that wraps the horizontal axis.
module vga_sync_gen
    import vga_sync_gen_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
    parameter int unsigned H_FP        = DEF_H_FP,
    parameter int unsigned H_SYNC      = DEF_H_SYNC,
    parameter int unsigned H_BP        = DEF_H_BP,
    parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
    parameter int unsigned V_FP        = DEF_V_FP,
    parameter int unsigned V_SYNC      = DEF_V_SYNC,
    parameter int unsigned V_BP        = DEF_V_BP,
    parameter bit          SYNC_ACTIVE = 1'b0,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ce,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hsync,
    output logic             vsync,
    output logic             blank,
    output logic             line_start,
    output logic             frame_start
);

    logic h_last_s;
    logic v_last_s;
    logic h_active_next_s;
    logic v_active_next_s;
    logic v_advance_s;

    logic blank_q;
    logic blank_d;
    logic line_start_q;
    logic line_start_d;
    logic frame_start_q;
    logic frame_start_d;

    assign v_advance_s = ce & h_last_s;

    sync_axis_counter #(
        .ACTIVE      (H_ACTIVE),
        .FP          (H_FP),
        .SYNC        (H_SYNC),
        .BP          (H_BP),
        .CNT_W       (CNT_W),
        .SYNC_ACTIVE (SYNC_ACTIVE)
    ) u_h_axis (
        .clock         (clock),
        .reset_n       (reset_n),
        .advance_i     (ce),
        .count_o       (hcount),
        .sync_o        (hsync),
        .at_last_o     (h_last_s),
        .active_next_o (h_active_next_s)
    );

    sync_axis_counter #(
        .ACTIVE      (V_ACTIVE),
        .FP          (V_FP),
        .SYNC        (V_SYNC),
        .BP          (V_BP),
        .CNT_W       (CNT_W),
        .SYNC_ACTIVE (SYNC_ACTIVE)
    ) u_v_axis (
        .clock         (clock),
        .reset_n       (reset_n),
        .advance_i     (v_advance_s),
        .count_o       (vcount),
        .sync_o        (vsync),
        .at_last_o     (v_last_s),
        .active_next_o (v_active_next_s)
    );

    // Blank and strobes for the position both axes are about to load.
    always_comb begin
        blank_d       = ~(h_active_next_s & v_active_next_s);
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (v_advance_s) begin
            line_start_d  = 1'b1;
            frame_start_d = v_last_s;
        end else begin
            line_start_d  = 1'b0;
            frame_start_d = 1'b0;
        end
    end

    // Strobes reload every clock so they drop after one cycle even while ce stays low.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            blank_q       <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            blank_q       <= blank_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign blank       = blank_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Randomised-ce scoreboard bench on a reduced raster (H 4/1/1/1, V 3/1/1/1).
// Expected outputs come from the count of enabled edges since reset, mapped to (h, v) by modulo arithmetic.
module tb_vga_sync_gen;

    localparam int unsigned HA = 4, HF = 1, HS = 1, HB = 1;
    localparam int unsigned VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int unsigned HT = HA + HF + HS + HB;
    localparam int unsigned VT = VA + VF + VS + VB;
    localparam int unsigned FRAME = HT * VT;
    localparam int unsigned CW = 4;
    localparam bit          SA = 1'b0;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          ce;
    logic [CW-1:0] hcount;
    logic [CW-1:0] vcount;
    logic          hsync;
    logic          vsync;
    logic          blank;
    logic          line_start;
    logic          frame_start;

    typedef struct packed {
        logic [CW-1:0] h;
        logic [CW-1:0] v;
        logic          hs;
        logic          vs;
        logic          bl;
        logic          ls;
        logic          fs;
    } obs_t;

    obs_t        act;
    obs_t        exp_q[$];
    int          total = 0;
    int          bad   = 0;
    int unsigned k     = 0;

    assign act = {hcount, vcount, hsync, vsync, blank, line_start, frame_start};

    always #5 clock = ~clock;

    vga_sync_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_ACTIVE(SA), .CNT_W(CW)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .ce          (ce),
        .hcount      (hcount),
        .vcount      (vcount),
        .hsync       (hsync),
        .vsync       (vsync),
        .blank       (blank),
        .line_start  (line_start),
        .frame_start (frame_start)
    );

    // Expected outputs after 'edges' enabled edges since reset; adv says this edge was enabled.
    function automatic obs_t model(input int unsigned edges, input bit adv);
        obs_t        o;
        int unsigned idx, h, v;
        if (edges == 0) begin
            h = HT - 1;
            v = VT - 1;
        end else begin
            idx = (edges - 1) % FRAME;
            h   = idx % HT;
            v   = idx / HT;
        end
        o.h  = CW'(h);
        o.v  = CW'(v);
        o.hs = (edges != 0 && h >= HA + HF && h < HA + HF + HS) ? SA : ~SA;
        o.vs = (edges != 0 && v >= VA + VF && v < VA + VF + VS) ? SA : ~SA;
        o.bl = (h >= HA) || (v >= VA);
        o.ls = adv && (edges != 0) && (h == 0);
        o.fs = o.ls && (v == 0);
        return o;
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s t=%0t: got h=%0d v=%0d hs=%b vs=%b bl=%b ls=%b fs=%b, want h=%0d v=%0d hs=%b vs=%b bl=%b ls=%b fs=%b",
                     name, $time, got.h, got.v, got.hs, got.vs, got.bl, got.ls, got.fs,
                     want.h, want.v, want.hs, want.vs, want.bl, want.ls, want.fs);
        end
    endtask

    task automatic step(input bit c);
        @(negedge clock);
        ce = c;
        if (reset_n && c) k++;
        exp_q.push_back(model(k, reset_n && c));
    endtask

    task automatic async_reset();
        @(negedge clock);
        ce = 1'($urandom);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset", act, model(0, 1'b0));
        k = 0;
        exp_q.push_back(model(0, 1'b0));
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset_n = 1'b1;
        ce      = 1'b0;
        exp_q.push_back(model(k, 1'b0));
    endtask

    // Monitor: one expectation per active edge, compared just after the edge.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) check("cycle", act, exp_q.pop_front());
        end
    end

    initial begin
        reset_n = 1'b0;
        ce      = 1'b0;
        repeat (3) step(1'($urandom));
        release_reset();

        repeat (2 * FRAME + 3) step(1'b1);
        repeat (300) step($urandom_range(0, 9) < 6);

        async_reset();
        repeat (2) step(1'($urandom));
        release_reset();
        repeat (FRAME + 4) step(1'b1);
        repeat (200) step($urandom_range(0, 3) == 0);

        async_reset();
        release_reset();
        repeat (FRAME * 3) step(1'($urandom));

        @(negedge clock);
        @(negedge clock);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
